// File: rtl/toggle_pkg.sv
// Shared types and default parameters for the toggle-encoded event decoder.
package toggle_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 4;

endpackage

// File: rtl/toggle_decoder_sync_chain.sv
// Multi-flop synchroniser bringing the asynchronous toggle line into clk.
module sync_chain #(
  parameter int SYNC_STAGES = toggle_pkg::DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_decoder.sv
// Receive-side toggle decoder: synchronise, detect level changes, pulse and
// count undelivered events with saturation and a sticky overflow flag.
module toggle_decoder
  import toggle_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tog_in,
  input  logic             evt_ready,
  input  logic             ovf_clr,
  output logic             evt_valid,
  output logic             evt_pulse,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  output state_t           state
);

  // Handshake: one event is consumed at each rising edge where evt_valid and
  // evt_ready are both high; evt_ready with evt_valid low has no effect.

  localparam int              WARM_LEN = SYNC_STAGES + 1;
  localparam int              WARM_W   = $clog2(WARM_LEN + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = '1;

  logic              s;
  logic              prev;
  logic [WARM_W-1:0] warm_cnt;
  logic              warm_done;
  logic              edge_det;
  logic              pop;
  logic [CNT_W-1:0]  pend_nxt;
  logic              ovf_set;
  state_t            state_nxt;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (tog_in),
    .q   (s)
  );

  // Suppressing edges until the chain has refilled hides a level held through reset.
  assign warm_done = (warm_cnt == WARM_W'(WARM_LEN));
  assign edge_det  = warm_done & (s ^ prev);
  assign evt_valid = (state != IDLE);
  assign pop       = evt_valid & evt_ready;

  always_comb begin
    pend_nxt = pending;
    ovf_set  = 1'b0;
    if (edge_det && !pop) begin
      if (pending == MAX_CNT) ovf_set  = 1'b1;
      else                    pend_nxt = pending + 1'b1;
    end else if (!edge_det && pop) begin
      pend_nxt = pending - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pend_nxt != '0) state_nxt = BUSY;
      BUSY: begin
        if (pend_nxt == '0)          state_nxt = IDLE;
        else if (pend_nxt == MAX_CNT) state_nxt = FULL;
      end
      FULL: if (pend_nxt != MAX_CNT) state_nxt = BUSY;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev      <= 1'b0;
      warm_cnt  <= '0;
      evt_pulse <= 1'b0;
      pending   <= '0;
      overflow  <= 1'b0;
      state     <= IDLE;
    end else begin
      prev      <= s;
      if (!warm_done) warm_cnt <= warm_cnt + WARM_W'(1);
      evt_pulse <= edge_det;
      pending   <= pend_nxt;
      // A new overflow in the same cycle as a clear keeps the flag set.
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      state     <= state_nxt;
    end
  end

endmodule

// File: tb/tb_toggle_decoder.sv
// Directed bench for toggle_decoder with hand-computed expectations.
module tb_toggle_decoder;
  import toggle_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       tog_in;
  logic       evt_ready;
  logic       ovf_clr;
  logic       evt_valid;
  logic       evt_pulse;
  logic [3:0] pending;
  logic       overflow;
  state_t     state;

  int n_total = 0;
  int n_bad   = 0;
  int pulses  = 0;

  always #5 clk = ~clk;

  toggle_decoder #(.SYNC_STAGES(2), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .tog_in    (tog_in),
    .evt_ready (evt_ready),
    .ovf_clr   (ovf_clr),
    .evt_valid (evt_valid),
    .evt_pulse (evt_pulse),
    .pending   (pending),
    .overflow  (overflow),
    .state     (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  // Advance n cycles, sampling 1ns after each edge and counting pulses.
  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (evt_pulse) pulses++;
    end
  endtask

  task automatic toggle_and_wait(input int n);
    tog_in = ~tog_in;
    run(n);
  endtask

  initial begin
    rst = 1'b0; tog_in = 1'b1; evt_ready = 1'b0; ovf_clr = 1'b0;
    run(3);
    check("rst_pending", 32'(pending), 0);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_pulse", 32'(evt_pulse), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_state", 32'(state), 32'(IDLE));

    // Level held high through reset must not be reported.
    rst = 1'b1;
    pulses = 0;
    run(20);
    check("hold_pulses", 32'(pulses), 0);
    check("hold_pending", 32'(pending), 0);
    check("hold_valid", 32'(evt_valid), 0);

    // Single toggle: pulse appears after the third edge.
    pulses = 0;
    toggle_and_wait(2);
    check("lat_pulse_early", 32'(evt_pulse), 0);
    run(1);
    check("lat_pulse", 32'(evt_pulse), 1);
    check("lat_pending", 32'(pending), 1);
    check("lat_valid", 32'(evt_valid), 1);
    run(1);
    check("lat_pulse_one", 32'(evt_pulse), 0);
    check("lat_pulses", 32'(pulses), 1);
    evt_ready = 1'b1;
    run(1);
    evt_ready = 1'b0;
    check("pop1_pending", 32'(pending), 0);
    check("pop1_valid", 32'(evt_valid), 0);
    check("pop1_state", 32'(state), 32'(IDLE));

    // Five spaced toggles, then drain one per cycle.
    pulses = 0;
    for (int i = 0; i < 5; i++) toggle_and_wait(4);
    check("five_pulses", 32'(pulses), 5);
    check("five_pending", 32'(pending), 5);
    evt_ready = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      run(1);
      check("drain_pending", 32'(pending), 32'(i));
    end
    run(1);
    check("no_underflow", 32'(pending), 0);
    check("drain_valid", 32'(evt_valid), 0);
    evt_ready = 1'b0;

    // Edge and pop in the same cycle at pending=3.
    for (int i = 0; i < 3; i++) toggle_and_wait(4);
    check("pre_both_pending", 32'(pending), 3);
    toggle_and_wait(2);
    evt_ready = 1'b1;
    run(1);
    evt_ready = 1'b0;
    check("both_pulse", 32'(evt_pulse), 1);
    check("both_pending", 32'(pending), 3);
    run(1);
    check("both_after", 32'(pending), 3);

    // Saturation.
    evt_ready = 1'b1;
    run(3);
    evt_ready = 1'b0;
    check("sat_start", 32'(pending), 0);
    pulses = 0;
    for (int i = 0; i < 15; i++) toggle_and_wait(4);
    check("sat15_pending", 32'(pending), 15);
    check("sat15_state", 32'(state), 32'(FULL));
    check("sat15_ovf", 32'(overflow), 0);
    toggle_and_wait(4);
    check("sat16_pulses", 32'(pulses), 16);
    check("sat16_pending", 32'(pending), 15);
    check("sat16_ovf", 32'(overflow), 1);
    check("sat16_state", 32'(state), 32'(FULL));
    ovf_clr = 1'b1;
    run(1);
    ovf_clr = 1'b0;
    check("clr_ovf", 32'(overflow), 0);
    check("clr_pending", 32'(pending), 15);
    evt_ready = 1'b1;
    run(1);
    evt_ready = 1'b0;
    check("full_pop_pending", 32'(pending), 14);
    check("full_pop_state", 32'(state), 32'(BUSY));

    // Refill to max, then overflow coinciding with a clear: set wins.
    toggle_and_wait(4);
    check("refill_pending", 32'(pending), 15);
    toggle_and_wait(2);
    ovf_clr = 1'b1;
    run(1);
    ovf_clr = 1'b0;
    check("setwin_pulse", 32'(evt_pulse), 1);
    check("setwin_ovf", 32'(overflow), 1);
    check("setwin_pending", 32'(pending), 15);

    // Reset mid-operation with pending=7, overflow=1.
    run(1);
    evt_ready = 1'b1;
    run(8);
    evt_ready = 1'b0;
    check("mid_pending", 32'(pending), 7);
    check("mid_ovf", 32'(overflow), 1);
    rst = 1'b0;
    run(1);
    rst = 1'b1;
    check("mid_rst_pending", 32'(pending), 0);
    check("mid_rst_ovf", 32'(overflow), 0);
    check("mid_rst_valid", 32'(evt_valid), 0);
    check("mid_rst_pulse", 32'(evt_pulse), 0);
    check("mid_rst_state", 32'(state), 32'(IDLE));
    pulses = 0;
    toggle_and_wait(8);
    check("warm_pulses", 32'(pulses), 0);
    check("warm_pending", 32'(pending), 0);
    toggle_and_wait(4);
    check("post_warm_pulses", 32'(pulses), 1);
    check("post_warm_pending", 32'(pending), 1);
    check("post_warm_valid", 32'(evt_valid), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
